gf3_syndrome_controller: RTL and testbench

- Sits directly downstream of the GF(3) variable nodes and consumes their 2-bit hard-decision symbols.
- Symbols arrive one per cycle as a serial stream ordered check-by-check.
- Evaluates every parity check as the sum over GF(3) of coeff × symbol, mod 3.
- Per decoding iteration, declares convergence, requests another iteration, or terminates at the iteration limit.

---
 rtl/gf3_pkg.sv | 50 +++++
 rtl/gf3_check_accum.sv | 49 ++++
 rtl/gf3_syndrome_controller.sv | 160 ++++++++++++++++
 tb/tb_gf3_syndrome_controller.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf3_pkg.sv
// gf3_pkg: shared GF(3) symbol type, constants, FSM states and
// mod-3 arithmetic helpers for the syndrome controller.
package gf3_pkg;

    typedef logic [1:0] gf3_t;

    localparam gf3_t GF3_ZERO = 2'd0;
    localparam gf3_t GF3_ONE  = 2'd1;
    localparam gf3_t GF3_TWO  = 2'd2;
    localparam gf3_t GF3_ILL  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EVAL
    } state_t;

    typedef struct packed {
        logic bad;
        gf3_t val;
    } gf3_res_t;

    // An illegal operand yields a nonzero value so a check can never pass on it.
    function automatic gf3_res_t gf3_mul(input gf3_t a, input gf3_t b);
        gf3_res_t r;
        r.bad = (a == GF3_ILL) || (b == GF3_ILL);
        r.val = GF3_ONE;
        if (!r.bad) begin
            if (a == GF3_ZERO || b == GF3_ZERO)
                r.val = GF3_ZERO;
            else if (a == b)
                r.val = GF3_ONE;
            else
                r.val = GF3_TWO;
        end
        return r;
    endfunction

    function automatic gf3_res_t gf3_add(input gf3_t a, input gf3_t b);
        gf3_res_t   r;
        logic [2:0] s;
        r.bad = (a == GF3_ILL) || (b == GF3_ILL);
        s     = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3)
            s = s - 3'd3;
        r.val = r.bad ? GF3_ONE : s[1:0];
        return r;
    endfunction

endpackage

// File: rtl/gf3_check_accum.sv
// gf3_check_accum: per-check mod-3 multiply-accumulate and
// failure detection on the final edge of each check.
module gf3_check_accum
    import gf3_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    input  logic last,
    input  gf3_t symbol,
    input  gf3_t coeff,
    output logic check_fail,
    output logic illegal
);

    gf3_t     acc;
    logic     bad;
    gf3_res_t prod;
    gf3_res_t sum;

    always_comb begin
        prod       = gf3_mul(coeff, symbol);
        sum        = gf3_add(acc, prod.val);
        illegal    = en && (prod.bad || coeff == GF3_ZERO);
        check_fail = en && last &&
                     (sum.val != GF3_ZERO || sum.bad || bad || illegal);
    end

    // bad remembers an illegal edge seen earlier in the same check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= GF3_ZERO;
            bad <= 1'b0;
        end else if (clear) begin
            acc <= GF3_ZERO;
            bad <= 1'b0;
        end else if (en) begin
            if (last) begin
                acc <= GF3_ZERO;
                bad <= 1'b0;
            end else begin
                acc <= sum.val;
                bad <= bad | illegal;
            end
        end
    end

endmodule

// File: rtl/gf3_syndrome_controller.sv
// gf3_syndrome_controller: GF(3) syndrome evaluation and iteration control.
// Define GF3_UNSAT_COUNT_EN to add the UNSAT_COUNT failed-check counter.
module gf3_syndrome_controller
    import gf3_pkg::*;
#(
    parameter int MAX_ITER       = 8,
    parameter int ITER_BITS      = 4,
    parameter int CHECK_CNT_BITS = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 IN_VALID,
    input  logic [1:0]           SYMBOL,
    input  logic [1:0]           COEFF,
    input  logic                 LAST_IN_CHECK,
    input  logic                 LAST_IN_FRAME,
    output logic                 BUSY,
    output logic                 NEXT_ITER,
    output logic                 DONE,
    output logic                 CONVERGED,
    output logic [ITER_BITS-1:0] ITER_COUNT,
    output logic                 FORMAT_ERR
`ifdef GF3_UNSAT_COUNT_EN
    ,
    output logic [CHECK_CNT_BITS-1:0] UNSAT_COUNT
`endif
);

    state_t               state;
    state_t               state_d;
    logic                 busy_d;
    logic                 next_iter_d;
    logic                 done_d;
    logic                 conv_d;
    logic                 ferr_d;
    logic                 fail;
    logic                 fail_d;
    logic [ITER_BITS-1:0] iter_d;
    logic [ITER_BITS-1:0] iter_inc;
    logic                 accept;
    logic                 start_go;
    logic                 frame_err;
    logic                 check_fail;
    logic                 illegal;

    assign accept    = IN_VALID && (state == ACCUM);
    assign start_go  = START && (state == IDLE);
    assign frame_err = accept && LAST_IN_FRAME && !LAST_IN_CHECK;
    assign iter_inc  = ITER_COUNT + 1'b1;

    gf3_check_accum u_accum (
        .clk        (CLK),
        .rst_n      (RST),
        .clear      (start_go),
        .en         (accept),
        .last       (LAST_IN_CHECK || LAST_IN_FRAME),
        .symbol     (SYMBOL),
        .coeff      (COEFF),
        .check_fail (check_fail),
        .illegal    (illegal)
    );

    always_comb begin
        state_d     = state;
        busy_d      = BUSY;
        next_iter_d = 1'b0;
        done_d      = 1'b0;
        conv_d      = CONVERGED;
        ferr_d      = FORMAT_ERR;
        fail_d      = fail;
        iter_d      = ITER_COUNT;
        unique case (state)
            IDLE: begin
                if (START) begin
                    state_d = ACCUM;
                    busy_d  = 1'b1;
                    conv_d  = 1'b0;
                    ferr_d  = 1'b0;
                    fail_d  = 1'b0;
                    iter_d  = '0;
                end
            end
            ACCUM: begin
                if (IN_VALID) begin
                    if (check_fail)
                        fail_d = 1'b1;
                    if (illegal || frame_err)
                        ferr_d = 1'b1;
                    if (LAST_IN_FRAME)
                        state_d = EVAL;
                end
            end
            EVAL: begin
                iter_d = iter_inc;
                if (!fail) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    conv_d  = 1'b1;
                end else if (iter_inc == ITER_BITS'(MAX_ITER)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    conv_d  = 1'b0;
                end else begin
                    state_d     = ACCUM;
                    next_iter_d = 1'b1;
                    fail_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            BUSY       <= 1'b0;
            NEXT_ITER  <= 1'b0;
            DONE       <= 1'b0;
            CONVERGED  <= 1'b0;
            FORMAT_ERR <= 1'b0;
            ITER_COUNT <= '0;
            fail       <= 1'b0;
        end else begin
            state      <= state_d;
            BUSY       <= busy_d;
            NEXT_ITER  <= next_iter_d;
            DONE       <= done_d;
            CONVERGED  <= conv_d;
            FORMAT_ERR <= ferr_d;
            ITER_COUNT <= iter_d;
            fail       <= fail_d;
        end
    end

`ifdef GF3_UNSAT_COUNT_EN
    logic [CHECK_CNT_BITS-1:0] unsat_d;

    always_comb begin
        unsat_d = UNSAT_COUNT;
        if (start_go || next_iter_d)
            unsat_d = '0;
        else if (check_fail && !(&UNSAT_COUNT))
            unsat_d = UNSAT_COUNT + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            UNSAT_COUNT <= '0;
        else
            UNSAT_COUNT <= unsat_d;
    end
`else
    logic unused_cnt_bits;
    assign unused_cnt_bits = (CHECK_CNT_BITS > 0);
`endif

endmodule

// File: tb/tb_gf3_syndrome_controller.sv
// tb_gf3_syndrome_controller: directed and randomized frames checked
// against a frame-level GF(3) parity model.
module tb_gf3_syndrome_controller;

    localparam int MAX_ITER = 8;
    localparam int IB       = 4;
    localparam int CB       = 8;

    typedef struct {
        int c;
        int s;
        bit lic;
        bit lif;
    } edge_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic          IN_VALID;
    logic [1:0]    SYMBOL;
    logic [1:0]    COEFF;
    logic          LAST_IN_CHECK;
    logic          LAST_IN_FRAME;
    logic          BUSY;
    logic          NEXT_ITER;
    logic          DONE;
    logic          CONVERGED;
    logic [IB-1:0] ITER_COUNT;
    logic          FORMAT_ERR;
`ifdef GF3_UNSAT_COUNT_EN
    logic [CB-1:0] UNSAT_COUNT;
`endif

    gf3_syndrome_controller #(
        .MAX_ITER       (MAX_ITER),
        .ITER_BITS      (IB),
        .CHECK_CNT_BITS (CB)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .START         (START),
        .IN_VALID      (IN_VALID),
        .SYMBOL        (SYMBOL),
        .COEFF         (COEFF),
        .LAST_IN_CHECK (LAST_IN_CHECK),
        .LAST_IN_FRAME (LAST_IN_FRAME),
        .BUSY          (BUSY),
        .NEXT_ITER     (NEXT_ITER),
        .DONE          (DONE),
        .CONVERGED     (CONVERGED),
        .ITER_COUNT    (ITER_COUNT),
        .FORMAT_ERR    (FORMAT_ERR)
`ifdef GF3_UNSAT_COUNT_EN
        ,
        .UNSAT_COUNT   (UNSAT_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int    n_chk  = 0;
    int    n_err  = 0;
    int    m_iter = 0;
    bit    m_ferr = 0;
    edge_t fr[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Frame-level reference: each check is sum(c*s) mod 3 over its edges.
    function automatic void model(output bit fail, output bit ferr,
                                  output int unsat);
        int acc;
        bit bad;
        fail = 0; ferr = 0; unsat = 0; acc = 0; bad = 0;
        foreach (fr[i]) begin
            if (fr[i].s > 2 || fr[i].c == 0 || fr[i].c == 3) begin
                bad  = 1;
                ferr = 1;
            end else begin
                acc += fr[i].c * fr[i].s;
            end
            if (fr[i].lif && !fr[i].lic)
                ferr = 1;
            if (fr[i].lic || fr[i].lif) begin
                if (bad || (acc % 3) != 0) begin
                    fail = 1;
                    unsat++;
                end
                acc = 0;
                bad = 0;
            end
        end
    endfunction

    task automatic add_edge(input int c, input int s, input bit lic,
                            input bit lif);
        edge_t e;
        e.c = c; e.s = s; e.lic = lic; e.lif = lif;
        fr.push_back(e);
    endtask

    // mode 0: aim to satisfy, 1: aim to fail, 2: random with illegal edges
    task automatic add_check(input int n, input int mode);
        int acc, c, s;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            c = int'($urandom_range(1, 2));
            s = int'($urandom_range(0, 2));
            if (k == n - 1 && mode == 0)
                s = (((3 - acc) % 3) * c) % 3;
            else if (k == n - 1 && mode == 1)
                s = (((3 - acc) % 3) * c + int'($urandom_range(1, 2))) % 3;
            else if (mode == 2 && $urandom_range(7) == 0) begin
                if ($urandom_range(1) == 0) s = 3;
                else c = ($urandom_range(1) == 0) ? 0 : 3;
            end
            acc = (acc + c * s) % 3;
            add_edge(c, s, k == n - 1, 1'b0);
        end
    endtask

    task automatic build_frame(input int mode);
        int nchk;
        fr.delete();
        nchk = int'($urandom_range(1, 4));
        for (int i = 0; i < nchk; i++)
            add_check(int'($urandom_range(1, 4)),
                      mode == 3 ? int'($urandom_range(0, 2)) : mode);
        fr[fr.size() - 1].lif = 1'b1;
        if (mode == 2 && $urandom_range(5) == 0)
            fr[fr.size() - 1].lic = 1'b0;
    endtask

    task automatic end_frame();
        fr[fr.size() - 1].lic = 1'b1;
        fr[fr.size() - 1].lif = 1'b1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            IN_VALID      = 1'b0;
            START         = 1'($urandom_range(1));
            SYMBOL        = 2'($urandom_range(3));
            COEFF         = 2'($urandom_range(3));
            LAST_IN_CHECK = 1'($urandom_range(1));
            LAST_IN_FRAME = 1'($urandom_range(1));
            @(posedge CLK); #1;
        end
        START = 1'b0;
    endtask

    task automatic send(input edge_t e);
        IN_VALID      = 1'b1;
        COEFF         = 2'(e.c);
        SYMBOL        = 2'(e.s);
        LAST_IN_CHECK = e.lic;
        LAST_IN_FRAME = e.lif;
        @(posedge CLK); #1;
        IN_VALID      = 1'b0;
        LAST_IN_CHECK = 1'b0;
        LAST_IN_FRAME = 1'b0;
    endtask

    task automatic start_decode();
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        m_iter = 0;
        m_ferr = 0;
        chk("start_busy", BUSY, 1);
        chk("start_iter", ITER_COUNT, 0);
        chk("start_conv", CONVERGED, 0);
        chk("start_ferr", FORMAT_ERR, 0);
    endtask

    task automatic play_frame(output bit finished);
        bit f, fe;
        int un;
        model(f, fe, un);
        m_iter++;
        m_ferr = m_ferr | fe;
        foreach (fr[i]) begin
            if ($urandom_range(3) == 0)
                gap(int'($urandom_range(1, 2)));
            send(fr[i]);
        end
        chk("eval_busy", BUSY, 1);
        chk("eval_done", DONE, 0);
        chk("eval_next", NEXT_ITER, 0);
`ifdef GF3_UNSAT_COUNT_EN
        chk("unsat", UNSAT_COUNT, un);
`endif
        @(posedge CLK); #1;
        finished = !f || (m_iter == MAX_ITER);
        chk("done", DONE, finished);
        chk("next_iter", NEXT_ITER, !finished);
        chk("busy", BUSY, !finished);
        chk("iter", ITER_COUNT, m_iter);
        chk("ferr", FORMAT_ERR, m_ferr);
        if (finished) begin
            chk("conv", CONVERGED, !f);
            @(posedge CLK); #1;
            chk("done_pulse", DONE, 0);
            chk("conv_hold", CONVERGED, !f);
            chk("iter_hold", ITER_COUNT, m_iter);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit fin;
        RST = 1'b0; START = 1'b0; IN_VALID = 1'b0;
        SYMBOL = 2'd0; COEFF = 2'd1;
        LAST_IN_CHECK = 1'b0; LAST_IN_FRAME = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_next", NEXT_ITER, 0);
        chk("rst_conv", CONVERGED, 0);
        chk("rst_iter", ITER_COUNT, 0);
        chk("rst_ferr", FORMAT_ERR, 0);
        RST = 1'b1;
        @(posedge CLK); #1;

        // all-zero codeword, two checks of three edges
        start_decode();
        fr.delete();
        for (int i = 0; i < 6; i++)
            add_edge(1, 0, i == 2 || i == 5, i == 5);
        play_frame(fin);
        chk("zero_fin", fin, 1);

        // 1 + 2 + 0 == 0 mod 3
        start_decode();
        fr.delete();
        add_edge(1, 1, 0, 0); add_edge(2, 1, 0, 0); add_edge(1, 0, 1, 1);
        play_frame(fin);

        // failing check every iteration up to the limit
        start_decode();
        do begin
            fr.delete();
            add_edge(1, 1, 0, 0); add_edge(1, 0, 1, 1);
            play_frame(fin);
        end while (!fin);
        chk("limit_iter", ITER_COUNT, MAX_ITER);

        // fail once, then converge
        start_decode();
        fr.delete();
        add_edge(2, 2, 1, 0); add_edge(1, 0, 1, 1);
        play_frame(fin);
        fr.delete();
        add_edge(2, 2, 0, 0); add_edge(1, 2, 1, 1);
        play_frame(fin);
        chk("fail_pass_iter", ITER_COUNT, 2);

        // illegal symbol mid-check; legal edges alone would sum to 0
        start_decode();
        fr.delete();
        add_edge(1, 1, 0, 0); add_edge(1, 3, 0, 0); add_edge(2, 1, 1, 0);
        add_edge(1, 0, 1, 1);
        play_frame(fin);
        build_frame(0);
        play_frame(fin);
        chk("ferr_sticky", FORMAT_ERR, 1);

        // checks summing to 1, 0, 2
        start_decode();
        fr.delete();
        add_edge(1, 1, 1, 0); add_edge(2, 0, 1, 0); add_edge(2, 1, 1, 1);
        play_frame(fin);
        fr.delete();
        add_edge(1, 0, 1, 1);
        play_frame(fin);

        // IN_VALID with frame markers and illegal data while idle
        for (int i = 0; i < 3; i++)
            send('{3, 3, 1'b0, 1'b1});
        chk("idle_busy", BUSY, 0);
        chk("idle_done", DONE, 0);
        chk("idle_ferr", FORMAT_ERR, m_ferr);

        // reset two cycles into ACCUM
        start_decode();
        send('{1, 1, 1'b0, 1'b0});
        send('{1, 2, 1'b0, 1'b0});
        RST = 1'b0;
        #1;
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_iter", ITER_COUNT, 0);
        repeat (3) begin
            @(posedge CLK); #1;
            chk("mid_rst_done", DONE, 0);
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        start_decode();
        build_frame(0);
        play_frame(fin);

        // randomized decodes
        for (int d = 0; d < 30; d++) begin
            start_decode();
            do begin
                build_frame(int'($urandom_range(0, 3)));
                play_frame(fin);
            end while (!fin);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
